// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and width helpers for the cache miss controller.
package cache_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StWb   = 2'd1;
    localparam state_t StFill = 2'd2;
    localparam state_t StDone = 2'd3;

    // Index width that never collapses to zero bits for a single entry.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_miss_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter import cache_ctrl_pkg::*; #(
    parameter int unsigned N = 2,
    localparam int unsigned W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_vld
);

    int unsigned idx;

    // Scan offsets from the far end down so the closest requester to ptr wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = idx[W-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Shared cache miss controller: RR miss arbitration, dirty write-back, then line fill.
// Optional hit/miss perf counters enabled by defining CACHE_CTRL_PERF_CNT_EN.
module cache_miss_ctrl import cache_ctrl_pkg::*; #(
    parameter int unsigned NUM_CLIENTS    = 2,
    parameter int unsigned BEATS_PER_LINE = 4,
    parameter int unsigned CNT_W          = 16,
    localparam int unsigned BW = idx_w(BEATS_PER_LINE),
    localparam int unsigned GW = idx_w(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] cl_req,
    input  logic [NUM_CLIENTS-1:0] cl_wr,
    input  logic [NUM_CLIENTS-1:0] cl_hit,
    input  logic [NUM_CLIENTS-1:0] cl_dirty,
    output logic [NUM_CLIENTS-1:0] cl_stall,
    output logic [NUM_CLIENTS-1:0] cl_set_dirty,
    output logic [NUM_CLIENTS-1:0] cl_fill_we,
    output logic [NUM_CLIENTS-1:0] cl_wb_re,
    output logic [BW-1:0]          beat_idx,
    output logic                   mem_req,
    output logic                   mem_we,
    input  logic                   mem_ack,
    output logic [GW-1:0]          grant,
`ifdef CACHE_CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0]       hit_cnt,
    output logic [CNT_W-1:0]       miss_cnt,
`endif
    output logic [1:0]             cur_state
);

    if (NUM_CLIENTS < 1 || BEATS_PER_LINE < 1 || CNT_W < 1) begin : g_param_chk
        $error("cache_miss_ctrl: NUM_CLIENTS, BEATS_PER_LINE and CNT_W must be >= 1");
    end

    state_t                   state_q, state_d;
    logic [BW-1:0]            beat_q, beat_d;
    logic [GW-1:0]            grant_q, grant_d;
    logic [GW-1:0]            rr_ptr_q, rr_ptr_d;
    logic                     wr_lat_q, wr_lat_d;
    logic [NUM_CLIENTS-1:0]   miss, hit_v;
    logic [GW-1:0]            win_idx;
    logic                     win_vld;
    logic                     last_beat;

    assign miss      = cl_req & ~cl_hit;
    assign hit_v     = cl_req & cl_hit;
    assign last_beat = (beat_q == BW'(BEATS_PER_LINE - 1));

    rr_arbiter #(.N(NUM_CLIENTS)) u_arb (
        .req     (miss),
        .ptr     (rr_ptr_q),
        .gnt_idx (win_idx),
        .gnt_vld (win_vld)
    );

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        wr_lat_d = wr_lat_q;
        case (state_q)
            StIdle: begin
                if (win_vld) begin
                    grant_d  = win_idx;
                    wr_lat_d = cl_wr[win_idx];
                    rr_ptr_d = (win_idx == GW'(NUM_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
                    state_d  = cl_dirty[win_idx] ? StWb : StFill;
                end
            end
            StWb, StFill: begin
                if (mem_ack) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = (state_q == StWb) ? StFill : StDone;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_lat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_lat_q <= wr_lat_d;
        end
    end

    // Gated by rst so every output is quiet during reset even if clients keep requesting.
    always_comb begin
        cl_stall     = '0;
        cl_set_dirty = '0;
        cl_fill_we   = '0;
        cl_wb_re     = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        if (!rst) begin
            case (state_q)
                StIdle: begin
                    cl_stall     = miss;
                    cl_set_dirty = hit_v & cl_wr;
                end
                StWb: begin
                    cl_stall          = '1;
                    mem_req           = 1'b1;
                    mem_we            = 1'b1;
                    cl_wb_re[grant_q] = 1'b1;
                end
                StFill: begin
                    cl_stall            = '1;
                    mem_req             = 1'b1;
                    cl_fill_we[grant_q] = mem_ack;
                end
                default: begin
                    cl_stall              = '1;
                    cl_set_dirty[grant_q] = wr_lat_q;
                end
            endcase
        end
    end

    assign beat_idx  = beat_q;
    assign grant     = grant_q;
    assign cur_state = state_q;

`ifdef CACHE_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state_q == StIdle && |hit_v && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (state_q == StIdle && win_vld && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed self-checking bench for cache_miss_ctrl (NC=2, BEATS=4).
module tb_cache_miss_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cl_req, cl_wr, cl_hit, cl_dirty;
    logic [1:0] cl_stall, cl_set_dirty, cl_fill_we, cl_wb_re;
    logic [1:0] beat_idx;
    logic       mem_req, mem_we, mem_ack;
    logic [0:0] grant;
    logic [1:0] cur_state;
`ifdef CACHE_CTRL_PERF_CNT_EN
    logic [3:0] hit_cnt, miss_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_miss_ctrl #(.NUM_CLIENTS(2), .BEATS_PER_LINE(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cl_req       (cl_req),
        .cl_wr        (cl_wr),
        .cl_hit       (cl_hit),
        .cl_dirty     (cl_dirty),
        .cl_stall     (cl_stall),
        .cl_set_dirty (cl_set_dirty),
        .cl_fill_we   (cl_fill_we),
        .cl_wb_re     (cl_wb_re),
        .beat_idx     (beat_idx),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .grant        (grant),
`ifdef CACHE_CTRL_PERF_CNT_EN
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
`endif
        .cur_state    (cur_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; cl_req = 2'b00; cl_wr = 2'b00; cl_hit = 2'b00; cl_dirty = 2'b00;
        mem_ack = 1'b0;
        tick(); settle();
        check("rst_state", 32'(cur_state), 32'd0);
        check("rst_stall", 32'(cl_stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_beat", 32'(beat_idx), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        tick();

        // 1: client1 write hit
        cl_req = 2'b10; cl_wr = 2'b10; cl_hit = 2'b10; settle();
        check("t1_stall", 32'(cl_stall), 32'd0);
        check("t1_set_dirty", 32'(cl_set_dirty), 32'h2);
        check("t1_mem_req", 32'(mem_req), 32'd0);
        tick();
        check("t1_state", 32'(cur_state), 32'd0);

        // 2: client0 clean read miss, ack every cycle
        cl_req = 2'b01; cl_wr = 2'b00; cl_hit = 2'b00; cl_dirty = 2'b00; mem_ack = 1'b1;
        settle();
        check("t2_idle_stall", 32'(cl_stall), 32'h1);
        tick();
        for (int b = 0; b < 4; b++) begin
            check("t2_state", 32'(cur_state), 32'd2);
            check("t2_beat", 32'(beat_idx), 32'(b));
            check("t2_fill_we", 32'(cl_fill_we), 32'h1);
            check("t2_mem_we", 32'(mem_we), 32'd0);
            check("t2_stall", 32'(cl_stall), 32'h3);
            tick();
        end
        check("t2_done", 32'(cur_state), 32'd3);
        check("t2_done_sd", 32'(cl_set_dirty), 32'd0);
        cl_hit = 2'b01;
        tick(); settle();
        check("t2_unstall", 32'(cl_stall), 32'd0);
        cl_req = 2'b00;
        tick();

        // 3: client1 dirty write miss, ack every 2nd cycle
        cl_req = 2'b10; cl_wr = 2'b10; cl_hit = 2'b00; cl_dirty = 2'b10; mem_ack = 1'b0;
        tick();
        cl_dirty = 2'b00;
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1'b0; settle();
            check("t3_wb_state", 32'(cur_state), 32'd1);
            check("t3_wb_beat", 32'(beat_idx), 32'(b));
            check("t3_wb_re", 32'(cl_wb_re), 32'h2);
            check("t3_wb_we", 32'(mem_we), 32'd1);
            check("t3_grant", 32'(grant), 32'd1);
            tick();
            mem_ack = 1'b1; settle();
            check("t3_wb_hold", 32'(beat_idx), 32'(b));
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            mem_ack = 1'b0; settle();
            check("t3_fill_state", 32'(cur_state), 32'd2);
            check("t3_fill_beat", 32'(beat_idx), 32'(b));
            check("t3_fill_noack", 32'(cl_fill_we), 32'd0);
            tick();
            mem_ack = 1'b1; settle();
            check("t3_fill_we", 32'(cl_fill_we), 32'h2);
            tick();
        end
        check("t3_done", 32'(cur_state), 32'd3);
        check("t3_done_sd", 32'(cl_set_dirty), 32'h2);
        cl_hit = 2'b10;
        tick(); settle();
        check("t3_hit_stall", 32'(cl_stall), 32'd0);
        cl_req = 2'b00; cl_wr = 2'b00;
        tick();

        // 4: both miss together, ptr back at 0
        cl_req = 2'b11; cl_hit = 2'b00; mem_ack = 1'b1; settle();
        check("t4_stall_both", 32'(cl_stall), 32'h3);
        tick();
        check("t4_grant0", 32'(grant), 32'd0);
        for (int b = 0; b < 4; b++) begin
            check("t4_fill0", 32'(cl_fill_we), 32'h1);
            check("t4_stall0", 32'(cl_stall), 32'h3);
            tick();
        end
        check("t4_done0", 32'(cur_state), 32'd3);
        cl_hit = 2'b01;
        tick(); settle();
        check("t4_idle_stall", 32'(cl_stall), 32'h2);
        tick();
        check("t4_grant1", 32'(grant), 32'd1);
        for (int b = 0; b < 4; b++) begin
            check("t4_fill1", 32'(cl_fill_we), 32'h2);
            tick();
        end
        check("t4_done1", 32'(cur_state), 32'd3);
        cl_hit = 2'b11;
        tick(); settle();
        check("t4_all_hit", 32'(cl_stall), 32'd0);

        // 5: ptr wrapped to 0 -> client0 first again; reset mid-fill at beat 2
        cl_hit = 2'b00;
        tick();
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_fill", 32'(cur_state), 32'd2);
        tick(); tick();
        check("t5_beat2", 32'(beat_idx), 32'd2);
        rst = 1'b1; settle();
        check("t5_rst_req", 32'(mem_req), 32'd0);
        check("t5_rst_stall", 32'(cl_stall), 32'd0);
        check("t5_rst_beat", 32'(beat_idx), 32'd0);
        check("t5_rst_state", 32'(cur_state), 32'd0);
        tick();
        rst = 1'b0; cl_req = 2'b00;
        tick();
        check("t5_idle", 32'(cur_state), 32'd0);
        check("t5_idle_req", 32'(mem_req), 32'd0);

`ifdef CACHE_CTRL_PERF_CNT_EN
        // 6: 20 back-to-back clean misses saturate a 4-bit miss counter
        check("t6_miss_rst", 32'(miss_cnt), 32'd0);
        cl_req = 2'b01; cl_hit = 2'b00; mem_ack = 1'b1;
        for (int m = 0; m < 20; m++) begin
            for (int c = 0; c < 6; c++) tick();
        end
        cl_req = 2'b00;
        tick();
        check("t6_miss_sat", 32'(miss_cnt), 32'd15);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
